// File: rtl/byte_serial_sub_pkg.sv
// Shared definitions for the byte-serial subtractor: byte width, FSM state
// encoding and the helper that sizes the beat counter.
package sub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        SUB_IDLE = 1'b0,
        SUB_BUSY = 1'b1
    } sub_state_e;

    // Counter must represent 0..max_bytes inclusive.
    function automatic int cnt_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/byte_serial_sub_cell.sv
// One byte of subtraction with borrow: {c,d} = a + ~b + !bi, bo = !c.
module byte_sub_cell
    import sub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              bi,
    output logic [BYTE_W-1:0] d,
    output logic              bo
);

    logic [BYTE_W:0] sum;

    // Subtract as add of the ones' complement; carry-out inverted is the borrow.
    always_comb begin
        sum = {1'b0, a} + {1'b0, ~b} + {{BYTE_W{1'b0}}, ~bi};
        d   = sum[BYTE_W-1:0];
        bo  = ~sum[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_sub.sv
// Byte-serial multi-byte subtractor, LS byte first, registered borrow chain,
// one output register stage with valid/ready on both sides.
// Optional feature: define SUB_OVF_EN to add out_ovf (signed overflow on the
// last beat of a word).
//
// state    | meaning
// SUB_IDLE | no word open; next beat starts a word with bin
// SUB_BUSY | word open; next beat chains the registered borrow
module byte_serial_sub
    import sub_pkg::*;
#(
    parameter int MAX_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_diff,
    output logic              out_last,
    output logic              out_bout,
    output logic              out_zero,
    output logic              out_err
`ifdef SUB_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int CNT_W = cnt_width(MAX_BYTES);

    sub_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              borrow_q,    borrow_d;
    logic              acc_q,       acc_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_diff_q,  out_diff_d;
    logic              out_last_q,  out_last_d;
    logic              out_bout_q,  out_bout_d;
    logic              out_zero_q,  out_zero_d;
    logic              out_err_q,   out_err_d;
`ifdef SUB_OVF_EN
    logic              out_ovf_q,   out_ovf_d;
`endif

    logic              accept;
    logic              start;
    logic              cell_bi;
    logic [BYTE_W-1:0] cell_d;
    logic              cell_bo;
    logic [CNT_W-1:0]  cnt_inc;
    logic              hit_max;
    logic              word_end;
    logic              acc_beat;

    byte_sub_cell u_cell (
        .a  (in_a),
        .b  (in_b),
        .bi (cell_bi),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Handshake, word start/end detection and next-state for all registers.
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        accept   = in_valid & in_ready;
        start    = (state_q == SUB_IDLE) | in_first;
        cell_bi  = start ? bin : borrow_q;
        cnt_inc  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
        hit_max  = (cnt_inc == CNT_W'(MAX_BYTES));
        word_end = in_last | hit_max;
        acc_beat = (start | acc_q) & (cell_d == '0);

        state_d     = state_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_diff_d  = out_diff_q;
        out_last_d  = out_last_q;
        out_bout_d  = out_bout_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
`ifdef SUB_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif

        if (accept) begin
            state_d     = word_end ? SUB_IDLE : SUB_BUSY;
            cnt_d       = word_end ? '0 : cnt_inc;
            borrow_d    = word_end ? 1'b0 : cell_bo;
            acc_d       = word_end ? 1'b1 : acc_beat;
            out_valid_d = 1'b1;
            out_diff_d  = cell_d;
            out_last_d  = word_end;
            out_bout_d  = word_end & cell_bo;
            out_zero_d  = word_end & acc_beat;
            // Missing in_first when idle, restart while busy, or forced end.
            out_err_d   = ((state_q == SUB_IDLE) & ~in_first)
                        | ((state_q == SUB_BUSY) & in_first)
                        | (hit_max & ~in_last);
`ifdef SUB_OVF_EN
            out_ovf_d   = word_end & (in_a[BYTE_W-1] ^ in_b[BYTE_W-1])
                                   & (in_a[BYTE_W-1] ^ cell_d[BYTE_W-1]);
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, chain and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SUB_IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            acc_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_diff_q  <= '0;
            out_last_q  <= 1'b0;
            out_bout_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef SUB_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_diff_q  <= out_diff_d;
            out_last_q  <= out_last_d;
            out_bout_q  <= out_bout_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
`ifdef SUB_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    // Drive ports straight from the output register.
    always_comb begin
        out_valid = out_valid_q;
        out_diff  = out_diff_q;
        out_last  = out_last_q;
        out_bout  = out_bout_q;
        out_zero  = out_zero_q;
        out_err   = out_err_q;
`ifdef SUB_OVF_EN
        out_ovf   = out_ovf_q;
`endif
    end

endmodule

// File: tb/tb_byte_serial_sub.sv
// Scoreboard bench for byte_serial_sub: word-level arithmetic reference model,
// random stalls on the output side, directed corner cases.
module tb_byte_serial_sub;

    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_first = 1'b0;
    logic       in_last = 1'b0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_diff;
    logic       out_last;
    logic       out_bout;
    logic       out_zero;
    logic       out_err;
`ifdef SUB_OVF_EN
    logic       out_ovf;
`else
    logic       out_ovf = 1'b0;
`endif

    byte_serial_sub #(.MAX_BYTES(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_last  (out_last),
        .out_bout  (out_bout),
        .out_zero  (out_zero),
        .out_err   (out_err)
`ifdef SUB_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] diff;
        logic       last;
        logic       bout;
        logic       zero;
        logic       err;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    exp_t last_got;
    exp_t held;
    bit   held_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: stalled

    // Reference model state: the word so far as plain integers.
    bit          m_in_word = 1'b0;
    int          m_n = 0;
    logic [71:0] m_a = '0;
    logic [71:0] m_b = '0;
    logic        m_bin = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Result beat = the byte of (A - B - bin) mod 256^n at the current position.
    function automatic exp_t model_beat(input logic [7:0] a, input logic [7:0] b,
                                        input logic first, input logic last, input logic bi);
        exp_t        e;
        logic [71:0] full;
        logic [71:0] mask;
        bit          start;
        e     = '0;
        start = !m_in_word || first;
        e.err = (m_in_word && first) || (!m_in_word && !first);
        if (start) begin
            m_a = '0; m_b = '0; m_n = 0; m_bin = bi;
        end
        m_a  = m_a | (72'(a) << (8 * m_n));
        m_b  = m_b | (72'(b) << (8 * m_n));
        m_n++;
        full   = m_a - m_b - 72'(m_bin);
        e.diff = 8'(full >> (8 * (m_n - 1)));
        e.last = last || (m_n == MAXB);
        if (!last && m_n == MAXB) e.err = 1'b1;
        if (e.last) begin
            mask      = (72'd1 << (8 * m_n)) - 72'd1;
            e.bout    = (m_a < (m_b + 72'(m_bin)));
            e.zero    = ((full & mask) == '0);
`ifdef SUB_OVF_EN
            e.ovf     = (a[7] ^ b[7]) & (a[7] ^ e.diff[7]);
`endif
            m_in_word = 1'b0;
        end else begin
            m_in_word = 1'b1;
        end
        return e;
    endfunction

    // Output-side ready generator, changes just after the rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 4) != 0;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: stability while stalled, scoreboard pop on each handshake.
    always @(negedge clk) begin
        exp_t got;
        got = '{diff: out_diff, last: out_last, bout: out_bout,
                zero: out_zero, err: out_err, ovf: out_ovf};
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (out_valid && held_valid) check("stable", 32'(got), 32'(held));
            if (out_valid && out_ready) begin
                held_valid = 1'b0;
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    check("beat", 32'(got), 32'(q.pop_front()));
                end
                last_got = got;
            end else if (out_valid) begin
                held       = got;
                held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic first, input logic last, input logic bi);
        int t;
        @(negedge clk);
        in_a = a; in_b = b; in_first = first; in_last = last; bin = bi;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            q.push_back(model_beat(a, b, first, last, bi));
            @(posedge clk);
            #1;
            check("latency", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rdy_mode = 2;
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_in_word = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_outs", 32'({out_diff, out_last, out_bout, out_zero, out_err, out_ovf}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        rdy_mode = 0;
    endtask

    initial begin
        int len;
        int nb;
        logic f;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_outs", 32'({out_diff, out_last, out_bout, out_zero, out_err, out_ovf}), 32'd0);
        rst = 1'b0;
        rdy_mode = 0;

        // Single byte 0x05 - 0x03
        send(8'h05, 8'h03, 1, 1, 0);
        drain();
        check("t1_word", 32'(last_got), 32'({8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

        // 0x0100 - 0x0001 and 0x1234 - 0x1234
        send(8'h00, 8'h01, 1, 0, 0);
        send(8'h01, 8'h00, 0, 1, 0);
        drain();
        check("t2_diff_bout_zero", 32'({last_got.diff, last_got.bout, last_got.zero}), 32'({8'h00, 1'b0, 1'b0}));
        send(8'h34, 8'h34, 1, 0, 0);
        send(8'h12, 8'h12, 0, 1, 0);
        drain();
        check("t2_zero", 32'(last_got.zero), 32'd1);

        // Underflow and borrow-in
        send(8'h00, 8'h01, 1, 1, 0);
        drain();
        check("t3_underflow", 32'({last_got.diff, last_got.bout}), 32'({8'hFF, 1'b1}));
        send(8'h10, 8'h0F, 1, 1, 1);
        drain();
        check("t3_bin", 32'({last_got.diff, last_got.bout, last_got.zero}), 32'({8'h00, 1'b0, 1'b1}));

        // Stall of 3 cycles in the middle of a 4-byte word
        send(8'h11, 8'h22, 1, 0, 0);
        drain();
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(8'h33, 8'h44, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_mode = 0;
        send(8'h55, 8'h66, 0, 0, 0);
        send(8'h77, 8'h88, 0, 1, 0);
        drain();

        // in_first while busy restarts with bin: 0x33 - 0x10 - 1
        send(8'h11, 8'h22, 1, 0, 0);
        send(8'h33, 8'h10, 1, 1, 1);
        drain();
        check("t5_restart", 32'({last_got.diff, last_got.last, last_got.err}), 32'({8'h22, 1'b1, 1'b1}));

        // Forced termination at MAX_BYTES
        for (int i = 0; i < MAXB; i++) send(8'(i + 1), 8'(i), i == 0, 0, 0);
        drain();
        check("t5_forced", 32'({last_got.last, last_got.err}), 32'({1'b1, 1'b1}));

        // Reset mid-word with a held result; next word must start clean
        send(8'h00, 8'h01, 1, 0, 0);
        do_reset();
        send(8'h05, 8'h03, 0, 1, 0);
        drain();
        check("t5_after_rst", 32'({last_got.diff, last_got.err}), 32'({8'h02, 1'b1}));

`ifdef SUB_OVF_EN
        send(8'h80, 8'h01, 1, 1, 0);
        drain();
        check("ovf_set", 32'({last_got.diff, last_got.ovf}), 32'({8'h7F, 1'b1}));
        send(8'h7F, 8'h01, 1, 1, 0);
        drain();
        check("ovf_clr", 32'(last_got.ovf), 32'd0);
`endif

        // Random words with random output stalls
        rdy_mode = 1;
        for (int w = 0; w < 3000; w++) begin
            len = $urandom_range(1, MAXB + 1);
            nb  = (len > MAXB) ? MAXB : len;
            for (int i = 0; i < nb; i++) begin
                f = (i == 0) ? (($urandom % 16) != 0) : (($urandom % 32) == 0);
                send(8'($urandom), 8'($urandom), f, (i == len - 1), 1'($urandom));
            end
        end
        rdy_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
